// File: rtl/sha256_pkg.sv
// Shared SHA-256 padding constants, padder FSM state type and block-count helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha256_pkg;

    // Size of one SHA-256 message block and of the trailing length field.
    localparam int SHA_BLOCK_BITS  = 512;
    localparam int SHA_BLOCK_BYTES = SHA_BLOCK_BITS / 8;
    localparam int SHA_LEN_BITS    = 64;
    localparam int SHA_LEN_BYTES   = SHA_LEN_BITS / 8;

    // Padder job sequence: capture request, build padded image, stream blocks, report.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } pad_state_t;

    // Number of 512-bit blocks needed for a message of len_bytes bytes once the
    // 0x80 marker and the 8-byte length field have been appended.
    function automatic int unsigned sha_num_blocks(input int unsigned len_bytes);
        return (len_bytes + SHA_LEN_BYTES) / SHA_BLOCK_BYTES + 1;
    endfunction

endpackage

// File: rtl/sha256_block_sel.sv
// Selects one 512-bit block out of the registered padded image by block index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds the index stable while a block is stalled.
module sha256_block_sel
    import sha256_pkg::*;
#(
    parameter int NUM_BLOCKS = 2,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_BLOCKS*SHA_BLOCK_BITS-1:0] i_img,
    input  logic [IDX_W-1:0]                     i_idx,
    output logic [SHA_BLOCK_BITS-1:0]            o_block
);

    // Block 0 sits at the image MSBs; an index past the last block yields zeros.
    always_comb begin
        o_block = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (i_idx == IDX_W'(b)) begin
                o_block = i_img[(NUM_BLOCKS-b)*SHA_BLOCK_BITS-1 -: SHA_BLOCK_BITS];
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: latches a message, builds its padded image, streams 512-bit blocks.
// Latency: first block_valid two cycles after start; done one cycle after the last transfer.
// Backpressure: block_valid/out/idx/last held until block_ready; optional byte masking via SHA256_PAD_MASK_EN.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter  int MAX_MSG_BYTES = 80,
    localparam int MAX_BLOCKS    = (MAX_MSG_BYTES + 8) / 64 + 1,
    localparam int LEN_W         = $clog2(MAX_MSG_BYTES + 2),
    localparam int IDX_W         = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MAX_MSG_BYTES*8-1:0] msg_in,
    input  logic [LEN_W-1:0]           msg_len,
    input  logic                       start,
    output logic [SHA_BLOCK_BITS-1:0]  block_out,
    output logic                       block_valid,
    input  logic                       block_ready,
    output logic                       block_last,
    output logic [IDX_W-1:0]           block_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int          IMG_BITS  = MAX_BLOCKS * SHA_BLOCK_BITS;
    localparam int unsigned IMG_BYTES = IMG_BITS / 8;
    localparam int          MSG_BITS  = MAX_MSG_BYTES * 8;

    pad_state_t                r_state;
    pad_state_t                w_state_nxt;

    logic [MSG_BITS-1:0]       r_msg;
    logic [LEN_W-1:0]          r_len;
    logic [IMG_BITS-1:0]       r_img;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          r_last_idx;
    logic                      r_err;

    logic [31:0]               w_len_i;
    logic                      w_len_bad;
    logic [31:0]               w_nblk;
    logic [31:0]               w_len_end;
    logic [SHA_LEN_BITS-1:0]   w_lenfield;
    logic [IMG_BITS-1:0]       w_msg_ext;
    logic [IMG_BITS-1:0]       w_img;
    logic [SHA_BLOCK_BITS-1:0] w_sel_block;
    logic                      w_xfer;

    // Length-derived quantities; the shift by 3 into a 64-bit field cannot overflow.
    assign w_len_i    = 32'(r_len);
    assign w_len_bad  = (w_len_i > 32'(MAX_MSG_BYTES));
    assign w_nblk     = sha_num_blocks(w_len_i);
    assign w_len_end  = w_nblk * 32'(SHA_BLOCK_BYTES);
    assign w_lenfield = {29'd0, w_len_i, 3'b000};
    assign w_msg_ext  = {r_msg, {(IMG_BITS-MSG_BITS){1'b0}}};

    // Build the padded image byte by byte: message, 0x80 marker, zeros, 64-bit bit length.
    always_comb begin
        w_img = '0;
        for (int unsigned k = 0; k < IMG_BYTES; k++) begin
            logic [7:0] v_byte;
            logic [2:0] v_off;
`ifdef SHA256_PAD_MASK_EN
            v_byte = (k < w_len_i) ? w_msg_ext[IMG_BITS-1-8*k -: 8] : 8'h00;
`else
            v_byte = w_msg_ext[IMG_BITS-1-8*k -: 8];
`endif
            v_off = 3'(w_len_end - 32'd1 - k);
            if (k == w_len_i) begin
                v_byte = 8'h80;
            end
            if ((k + 32'(SHA_LEN_BYTES) >= w_len_end) && (k < w_len_end)) begin
                v_byte = w_lenfield[8*v_off +: 8];
            end
            w_img[IMG_BITS-1-8*k -: 8] = v_byte;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        block_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        w_xfer      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = w_len_bad ? ST_DONE : ST_EMIT;
            end
            ST_EMIT: begin
                block_valid = 1'b1;
                w_xfer      = block_ready;
                if (block_ready && (r_idx == r_last_idx)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                error       = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job datapath: capture request in IDLE, register image in LOAD, advance index per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg      <= '0;
            r_len      <= '0;
            r_img      <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_msg <= msg_in;
                r_len <= msg_len;
                r_err <= 1'b0;
            end
            if (r_state == ST_LOAD) begin
                r_idx <= '0;
                r_err <= w_len_bad;
                if (!w_len_bad) begin
                    r_img      <= w_img;
                    r_last_idx <= IDX_W'(w_nblk - 32'd1);
                end
            end
            if (w_xfer) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    sha256_block_sel #(
        .NUM_BLOCKS (MAX_BLOCKS),
        .IDX_W      (IDX_W)
    ) u_block_sel (
        .i_img   (r_img),
        .i_idx   (r_idx),
        .o_block (w_sel_block)
    );

    // Block outputs are only driven while a block is on offer.
    assign block_out  = block_valid ? w_sel_block : '0;
    assign block_last = block_valid && (r_idx == r_last_idx);
    assign block_idx  = r_idx;

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter MAX_MSG_BYTES, default 80, meaning the largest message accepted, in bytes.
REQ-002 SHALL have localparam MAX_BLOCKS = (MAX_MSG_BYTES+8)/64+1, meaning the output block count at maximum length.
REQ-003 SHALL have clk  input  1  meaning the single clock; rising-edge.
REQ-004 SHALL have rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have msg_in  input  MAX_MSG_BYTES*8  meaning the message, big-endian; byte 0 is at the MSBs.
REQ-006 SHALL have msg_len  input  $clog2(MAX_MSG_BYTES+2)  meaning the message length in bytes.
REQ-007 SHALL have start  input  1  meaning a request to pad, sampled only in IDLE.
REQ-008 SHALL have block_out  output  512  meaning the current padded block; byte 0 of the block is at [511:504].
REQ-009 SHALL have block_valid  output  1  meaning block_out is valid.
REQ-010 SHALL have block_ready  input  1  meaning the consumer accepts; a transfer occurs when valid and ready are both high.
REQ-011 SHALL have block_last  output  1  meaning the current block is the final block.
REQ-012 SHALL have block_idx  output  $clog2(MAX_BLOCKS+1)  meaning the index of the current block, counted from 0.
REQ-013 SHALL have busy  output  1  meaning the state is not IDLE.
REQ-014 SHALL have done  output  1  meaning a one-cycle pulse at the end of a job.
REQ-015 SHALL have error  output  1  meaning a one-cycle pulse, coincident with done, when msg_len > MAX_MSG_BYTES.

Function
REQ-016 SHALL implement the FSM IDLE -> LOAD -> EMIT -> DONE -> IDLE.
- IDLE -> LOAD on start.
- LOAD -> EMIT always for a legal length.
- LOAD -> DONE when the length is illegal.
REQ-017 SHALL latch msg_in and msg_len in IDLE when start=1; start in any other state SHALL be ignored.
REQ-018 SHALL, in LOAD, register the padded image, byte by byte:
- bytes 0..L-1 = message bytes;
- byte L = 8'h80;
- zero bytes follow;
- the final 8 bytes of block N-1 = L*8 as a 64-bit big-endian value.
REQ-019 SHALL compute the block count N = (L+8)/64+1 using integer division.
REQ-020 SHALL, in EMIT, hold block_valid=1 with block_out, block_idx and block_last stable until a transfer occurs.
REQ-021 SHALL, on each transfer, increment block_idx; after the transfer of block N-1 the FSM SHALL go to DONE.
REQ-022 SHALL assert block_last only while block_idx==N-1 and block_valid=1.
REQ-023 SHALL make the first block_valid appear exactly 2 cycles after the start cycle.
REQ-024 SHALL make done a pulse for exactly 1 cycle in DONE; the next cycle SHALL be IDLE, where a new start is accepted.
REQ-025 SHALL pad an illegal length (L>MAX_MSG_BYTES) as follows: no blocks emitted; done=1 and error=1 one cycle after LOAD.
REQ-026 SHALL handle L=0 as a single block: 8'h80 followed by zeros, with a length field of 0.
REQ-027 SHALL produce a length field for which L*8 does not overflow 64 bits for any legal parameter value.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE from any state, including mid-EMIT.
REQ-029 SHALL reset these outputs to 0: block_valid, block_last, block_idx, busy, done, error and block_out.
REQ-030 SHALL, after reset, never resume a partially emitted job.

Configuration
REQ-031 SHALL, with SHA256_PAD_MASK_EN defined, force msg_in bytes at index >= L to zero before padding.
REQ-032 SHALL, without SHA256_PAD_MASK_EN, pass msg_in bytes beyond L+1 unmodified; upstream SHALL guarantee those bytes are zero.

Structure
REQ-033 SHALL take the following from package sha256_pkg:
- constants SHA_BLOCK_BITS=512 and SHA_LEN_BITS=64;
- the padder state enum;
- a function computing the block count from a byte length.
REQ-034 SHALL place block selection (padded image, index -> 512-bit slice) in combinational sub-module sha256_block_sel.

Verification
REQ-035 SHALL cover "abc" (L=3): one block, 0x61626380 followed by zeros ending in 0x...0018; block_last=1; done 1 cycle after the transfer.
REQ-036 SHALL cover L=80 (bitcoin header): two blocks; block 1 = 0x80 after 16 header bytes, ending in length 0x280; block_idx goes 0 then 1.
REQ-037 SHALL cover the boundaries: L=55 gives N=1; L=56 gives N=2 with 0x80 in block 0 and the length in block 1; L=0 gives 0x80 followed by zeros.
REQ-038 SHALL cover backpressure: block_ready low for 5 cycles; block_out/idx/last SHALL stay constant; the transfer occurs on the 6th cycle.
REQ-039 SHALL cover illegal length and ignored start: L=81 with MAX=80 gives error=done=1 pulse and no block_valid; start pulsed during EMIT is ignored.
REQ-040 SHALL cover reset mid-job: rst during block 0 of an L=80 job gives all outputs 0 on the next cycle; a fresh start then produces block 0 again.
